// File: rtl/single_ttc_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : single_ttc_decoder
// Brief    : 3-symbol TTC frame decoder with local BCID/EVID counters.
// Revision : 1.0 - initial release
// ============================================================================
module single_ttc_decoder #(
    parameter int BC_MAX = 3563
) (
    input  logic        clk_40,
    input  logic        rst_40,
    input  logic [1:0]  encode_ttc,
    output logic        trigger,
    output logic        bc_reset,
    output logic        event_reset,
    output logic        master_reset,
    output logic        frame_err,
    output logic [11:0] bcid,
    output logic [11:0] evid,
    output logic        fpga_bcr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAY1 = 2'd1,
        ST_PAY2 = 2'd2
    } state_t;

    localparam logic [1:0]  C_SYM_START = 2'b11;
    localparam logic [11:0] C_BC_MAX    = 12'(BC_MAX);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_frame_done;
    logic       w_empty_frame;
    logic [1:0] r_s1;

    always_ff @(posedge clk_40 or posedge rst_40) begin
        if (rst_40) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Only IDLE looks for a start symbol; payload slots take whatever arrives.
    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (encode_ttc == C_SYM_START) begin
                    w_state_next = ST_PAY1;
                end
            end
            ST_PAY1: begin
                w_state_next = ST_PAY2;
            end
            ST_PAY2: begin
                w_state_next = ST_IDLE;
                w_frame_done = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_empty_frame = (r_s1 == 2'b00) && (encode_ttc == 2'b00);

    always_ff @(posedge clk_40 or posedge rst_40) begin
        if (rst_40) begin
            r_s1 <= 2'b00;
        end else if (r_state == ST_PAY1) begin
            r_s1 <= encode_ttc;
        end
    end

    // S2 is consumed directly from the input on the frame's last edge.
    always_ff @(posedge clk_40 or posedge rst_40) begin
        if (rst_40) begin
            trigger      <= 1'b0;
            bc_reset     <= 1'b0;
            event_reset  <= 1'b0;
            master_reset <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            trigger      <= w_frame_done & r_s1[1];
            bc_reset     <= w_frame_done & r_s1[0];
            event_reset  <= w_frame_done & encode_ttc[1];
            master_reset <= w_frame_done & encode_ttc[0];
            frame_err    <= w_frame_done & w_empty_frame;
        end
    end

    always_ff @(posedge clk_40 or posedge rst_40) begin
        if (rst_40) begin
            bcid <= 12'd0;
        end else if (bc_reset || master_reset || (bcid == C_BC_MAX)) begin
            bcid <= 12'd0;
        end else begin
            bcid <= bcid + 12'd1;
        end
    end

    // A reset command wins over a trigger in the same cycle.
    always_ff @(posedge clk_40 or posedge rst_40) begin
        if (rst_40) begin
            evid <= 12'd0;
        end else if (event_reset || master_reset) begin
            evid <= 12'd0;
        end else if (trigger) begin
            evid <= evid + 12'd1;
        end
    end

    assign fpga_bcr = (bcid == C_BC_MAX);

endmodule
`default_nettype wire

// File: doc/single_ttc_decoder.md
SINGLE_TTC_DECODER -- requirements
Module: single_ttc_decoder

Interface
REQ-001 SHALL have parameter BC_MAX, default 3563, last BCID value before wrap (orbit length minus 1).
REQ-002 SHALL have port clk_40  input  1  40 MHz system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_40  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port encode_ttc  input  2  encoded TTC symbol stream, one symbol per clk_40 cycle, already synchronous to clk_40.
REQ-005 SHALL have port trigger  output  1  decoded L1 trigger, one-cycle pulse.
REQ-006 SHALL have port bc_reset  output  1  decoded bunch-counter reset, one-cycle pulse.
REQ-007 SHALL have port event_reset  output  1  decoded event-counter reset, one-cycle pulse.
REQ-008 SHALL have port master_reset  output  1  decoded master reset, one-cycle pulse.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on an empty (all-zero payload) frame.
REQ-010 SHALL have port bcid  output  12  local bunch-crossing counter.
REQ-011 SHALL have port evid  output  12  local event counter.
REQ-012 SHALL have port fpga_bcr  output  1  one-cycle pulse while bcid == BC_MAX (local orbit marker).

Function
REQ-013 SHALL decode 3-symbol frames: S0 = 2'b11 (start), S1 = {trigger, bc_reset}, S2 = {event_reset, master_reset}, on consecutive cycles; idle symbol 2'b00.
REQ-014 SHALL implement FSM IDLE -> PAY1 -> PAY2 -> IDLE: IDLE to PAY1 only on sampling 2'b11; PAY1 captures S1 unconditionally; PAY2 captures S2 unconditionally.
REQ-015 SHALL ignore any non-11 symbol in IDLE, including 2'b01 and 2'b10.
REQ-016 SHALL treat 2'b11 sampled in PAY1/PAY2 as payload, never as a new start.
REQ-017 SHALL assert every command bit set in S1/S2 on its output for exactly one cycle, in the cycle after the edge sampling S2 (latency 3 cycles from S0 edge); multiple commands in one frame SHALL pulse in the same cycle.
REQ-018 SHALL accept back-to-back frames: 2'b11 on the cycle after S2 starts a new frame with no idle gap.
REQ-019 SHALL pulse frame_err, with no command outputs, when S1 = S2 = 2'b00.
REQ-020 SHALL increment bcid each cycle, wrapping BC_MAX -> 0.
REQ-021 SHALL load bcid to 0 on the edge ending a cycle in which bc_reset or master_reset is high.
REQ-022 SHALL increment evid on the edge ending a trigger-high cycle, wrapping 4095 -> 0.
REQ-023 SHALL load evid to 0 when event_reset or master_reset is high, overriding a simultaneous trigger (result 0, not 1).
REQ-024 SHALL derive fpga_bcr combinationally from the registered bcid (high exactly while bcid == BC_MAX).
REQ-025 SHALL register all pulse outputs (trigger, bc_reset, event_reset, master_reset, frame_err); no combinational path from encode_ttc.

Reset
REQ-026 SHALL, while rst_40 is high, force FSM to IDLE, all pulse outputs to 0, bcid = 0, evid = 0, fpga_bcr = 0.
REQ-027 SHALL discard a frame partially received when rst_40 asserts; after release, decoding resumes only at the next 2'b11 sampled in IDLE.
REQ-028 SHALL restart bcid counting from 0 on the first edge after rst_40 deasserts.

Verification
REQ-029 SHALL cover: frame 11,10,00 -> trigger pulse 1 cycle, 3 cycles after S0 edge; evid 0 -> 1; other outputs 0.
REQ-030 SHALL cover: frame 11,11,11 -> trigger, bc_reset, event_reset, master_reset all pulse in same cycle; then bcid = 0, evid = 0.
REQ-031 SHALL cover: frames 11,01,00 then 11,00,10 back-to-back -> bc_reset pulse, then event_reset pulse exactly 3 cycles later.
REQ-032 SHALL cover: free run of 3565 cycles with no frames after reset -> fpga_bcr high only when bcid = 3563, then bcid = 0, then 1.
REQ-033 SHALL cover: frame 11,00,00 -> frame_err pulse, no command pulses, counters unaffected; isolated 01/10 in IDLE -> no output.
REQ-034 SHALL cover: rst_40 asserted asynchronously after S1 of 11,10,… -> no trigger pulse; evid stays 0; next full frame decodes normally.
